// File: rtl/data_mem_arbiter_pkg.sv
// ============================================================================
// Module      : data_mem_arbiter_pkg
// Description : Shared types and constants for the two-port byte-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_arbiter_pkg;

    localparam int BYTES_PER_WORD = 3;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;
    localparam int DEF_MEM_BYTES  = 128;
    localparam int DEF_ADDR_W     = 24;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B0   = 3'd1,
        S_B1   = 3'd2,
        S_B2   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Big-endian byte select: index 0 is the MSB of the word.
    function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] word,
                                             input logic [1:0]        idx);
        case (idx)
            2'd0:    word_byte = word[23:16];
            2'd1:    word_byte = word[15:8];
            default: word_byte = word[7:0];
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_arbiter_rr_arbiter_2.sv
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-request round-robin picker; one-hot grant while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       req0,
    input  logic       req1,
    output logic [1:0] grant
);

    logic r_last_grant;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req0 && req1) begin
                grant = r_last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = {req1, req0};
            end
        end
    end

    // A lone request still moves the pointer, so the other port wins the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (en && (req0 || req1)) begin
            r_last_grant <= grant[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// Module      : data_mem_arbiter
// Description : Shares a byte-wide single-port memory between two 24-bit word
//               requesters, splitting each word into three big-endian bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              write0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [WORD_W-1:0] wdata0,
    output logic              ready0,
    input  logic              req1,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WORD_W-1:0] wdata1,
    output logic              ready1,
    output logic [WORD_W-1:0] rdata,
    output logic              error,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam logic [ADDR_W-1:0] c_MAX_ADDR = ADDR_W'(MEM_BYTES - BYTES_PER_WORD);

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          w_grant;
    logic                w_take;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_addr_bad;
    logic                w_in_byte;
    logic [1:0]          w_byte_idx;

    logic                r_port;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic [WORD_W-1:0]   r_rdata;
    logic                r_error;

    rr_arbiter_2 u_rr_arbiter_2 (
        .clk   (clk),
        .rst   (rst),
        .en    (r_state == S_IDLE),
        .req0  (req0),
        .req1  (req1),
        .grant (w_grant)
    );

    assign w_take     = |w_grant;
    assign w_sel_addr = w_grant[1] ? addr1 : addr0;
    assign w_addr_bad = w_sel_addr > c_MAX_ADDR;

    always_comb begin
        w_next_state = r_state;
        w_in_byte    = 1'b0;
        w_byte_idx   = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_next_state = w_addr_bad ? S_DONE : S_B0;
                end
            end
            S_B0: begin
                w_next_state = S_B1;
                w_in_byte    = 1'b1;
                w_byte_idx   = 2'd0;
            end
            S_B1: begin
                w_next_state = S_B2;
                w_in_byte    = 1'b1;
                w_byte_idx   = 2'd1;
            end
            S_B2: begin
                w_next_state = S_DONE;
                w_in_byte    = 1'b1;
                w_byte_idx   = 2'd2;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Strobe is cut by reset itself so an interrupted store never writes another byte.
    assign mem_write = w_in_byte & r_write & ~rst;
    assign mem_addr  = w_in_byte ? (r_addr + ADDR_W'(w_byte_idx)) : '0;
    assign mem_wdata = mem_write ? word_byte(r_wdata, w_byte_idx) : 8'h00;

    assign ready0 = (r_state == S_DONE) & ~r_port;
    assign ready1 = (r_state == S_DONE) &  r_port;
    assign error  = (r_state == S_DONE) &  r_error;
    assign busy   = (r_state != S_IDLE);
    assign rdata  = r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_port  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_take) begin
                r_port  <= w_grant[1];
                r_write <= w_grant[1] ? write1 : write0;
                r_addr  <= w_sel_addr;
                r_wdata <= w_grant[1] ? wdata1 : wdata0;
                r_rdata <= '0;
                r_error <= w_addr_bad;
            end else if (w_in_byte && !r_write) begin
                case (w_byte_idx)
                    2'd0:    r_rdata[23:16] <= mem_rdata;
                    2'd1:    r_rdata[15:8]  <= mem_rdata;
                    default: r_rdata[7:0]   <= mem_rdata;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Directed bench with a transaction-level model and per-cycle compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, write0, req1, write1;
    logic [23:0] addr0, wdata0, addr1, wdata1;
    logic        ready0, ready1, error, busy, mem_write;
    logic [23:0] rdata, mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  ram     [0:127];
    logic [7:0]  mdl_mem [0:127];

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cycles = 0;
    bit checking = 1'b0;

    // Model state: one transaction in flight, described by its grant edge.
    int          cyc = 0;
    bit          act = 1'b0;
    int          g_cyc = 0;
    bit          g_port, g_wr, g_bad;
    logic [23:0] g_addr, g_wdata, g_rdata;
    bit          last = 1'b1;

    always #5 clk = ~clk;

    data_mem_arbiter #(.MEM_BYTES(128), .ADDR_W(24)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .write0(write0), .addr0(addr0), .wdata0(wdata0), .ready0(ready0),
        .req1(req1), .write1(write1), .addr1(addr1), .wdata1(wdata1), .ready1(ready1),
        .rdata(rdata), .error(error), .busy(busy),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [23:0] w, input int k);
        logic [23:0] s;
        s = w >> (16 - 8 * k);
        return s[7:0];
    endfunction

    always_comb mem_rdata = (mem_addr < 24'd128) ? ram[mem_addr[6:0]] : 8'h00;

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = 8'(i) ^ 8'h55;
        forever begin
            @(posedge clk);
            if (mem_write && mem_addr < 24'd128) ram[mem_addr[6:0]] = mem_wdata;
        end
    end

    // Transaction-level model: grants, latency offsets and byte commits.
    initial begin
        int k, dly;
        bit p;
        for (int i = 0; i < 128; i++) mdl_mem[i] = 8'(i) ^ 8'h55;
        forever begin
            @(posedge clk);
            if (rst) begin
                act  = 1'b0;
                last = 1'b1;
            end else if (act && !g_bad && g_wr) begin
                k = cyc - g_cyc;
                if (k >= 0 && k <= 2) mdl_mem[7'(g_addr + 24'(k))] = exp_byte(g_wdata, k);
            end
            cyc++;
            dly = g_bad ? 0 : 3;
            if (!rst && (!act || cyc >= g_cyc + dly + 2) && (req0 || req1)) begin
                p       = (req0 && req1) ? ~last : req1;
                last    = p;
                g_port  = p;
                g_wr    = p ? write1 : write0;
                g_addr  = p ? addr1 : addr0;
                g_wdata = p ? wdata1 : wdata0;
                g_bad   = g_addr > 24'd125;
                g_rdata = (g_bad || g_wr) ? 24'h0 :
                          {mdl_mem[g_addr[6:0]], mdl_mem[7'(g_addr + 24'd1)], mdl_mem[7'(g_addr + 24'd2)]};
                act     = 1'b1;
                g_cyc   = cyc;
            end
        end
    end

    initial begin
        int k, dly;
        bit e_ready, e_busy, e_strobe;
        forever begin
            @(negedge clk);
            if (checking) begin
                if (rst) begin
                    chk("mem_write_in_reset", mem_write, 0);
                end else begin
                    dly      = g_bad ? 0 : 3;
                    k        = cyc - g_cyc;
                    e_ready  = act && (cyc == g_cyc + dly);
                    e_busy   = act && (cyc <= g_cyc + dly);
                    e_strobe = act && !g_bad && k >= 0 && k <= 2;
                    chk("ready0", ready0, e_ready && !g_port);
                    chk("ready1", ready1, e_ready && g_port);
                    chk("busy", busy, e_busy);
                    chk("mem_write", mem_write, e_strobe && g_wr);
                    chk("mem_addr", mem_addr, e_strobe ? g_addr + 24'(k) : 24'h0);
                    if (e_strobe && g_wr) chk("mem_wdata", mem_wdata, exp_byte(g_wdata, k));
                    if (e_ready) begin
                        chk("error", error, g_bad);
                        if (g_bad || !g_wr) chk("rdata", rdata, g_rdata);
                    end
                    if (mem_write) wr_cycles++;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_one(input bit p, input bit wr, input logic [23:0] a, input logic [23:0] d,
                           output int lat, output logic [23:0] rd, output bit er);
        int  m;
        bit  got;
        @(posedge clk); #1;
        if (p) begin req1 = 1'b1; write1 = wr; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; write0 = wr; addr0 = a; wdata0 = d; end
        m = cyc; got = 1'b0; lat = -1; rd = '0; er = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((p ? ready1 : ready0) === 1'b1) begin
                got = 1'b1; lat = cyc - (m + 1); rd = rdata; er = error;
            end
        end
        chk("ready_timeout", got, 1);
        @(posedge clk); #1;
        if (p) req1 = 1'b0; else req0 = 1'b0;
    endtask

    int order[$];

    task automatic tie(input logic [23:0] a0, input logic [23:0] a1, output int gap);
        bit got0, got1, s0, s1;
        int c0, c1;
        @(posedge clk); #1;
        req0 = 1'b1; write0 = 1'b0; addr0 = a0;
        req1 = 1'b1; write1 = 1'b0; addr1 = a1;
        got0 = 1'b0; got1 = 1'b0; c0 = 0; c1 = 0;
        for (int i = 0; i < 40 && !(got0 && got1); i++) begin
            @(negedge clk);
            s0 = (ready0 === 1'b1); s1 = (ready1 === 1'b1);
            if (s0) begin got0 = 1'b1; c0 = cyc; order.push_back(0); end
            if (s1) begin got1 = 1'b1; c1 = cyc; order.push_back(1); end
            @(posedge clk); #1;
            if (s0) req0 = 1'b0;
            if (s1) req1 = 1'b0;
        end
        chk("tie_both_served", {30'd0, got1, got0}, 3);
        gap = c1 - c0;
    endtask

    initial begin
        int          lat, gap, m;
        logic [23:0] rd;
        bit          er, seen;
        rst = 1'b1;
        req0 = 1'b0; write0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; write1 = 1'b0; addr1 = '0; wdata1 = '0;
        @(posedge clk); #1;
        checking = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {ready1, ready0}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem", {mem_write, mem_addr, mem_wdata}, 0);
        chk("rst_rdata_error", {rdata, error}, 0);

        // Store then load back across ports.
        wr_cycles = 0;
        run_one(1'b0, 1'b1, 24'h10, 24'hA1B2C3, lat, rd, er);
        chk("t1_latency", lat, 3);
        chk("t1_write_cycles", wr_cycles, 3);
        chk("t1_mem", {ram[16], ram[17], ram[18]}, 24'hA1B2C3);
        run_one(1'b1, 1'b0, 24'h10, 24'h0, lat, rd, er);
        chk("t2_rdata", rd, 24'hA1B2C3);
        chk("t2_error", er, 0);
        chk("t2_latency", lat, 3);

        // Ties after reset alternate starting with port 0, five cycles apart.
        do_reset();
        tie(24'h00, 24'h03, gap);
        chk("t3_gap_a", gap, 5);
        tie(24'h06, 24'h09, gap);
        chk("t3_gap_b", gap, 5);
        chk("t3_order", {order[0][7:0], order[1][7:0], order[2][7:0], order[3][7:0]}, 32'h00010001);

        // Range boundary.
        wr_cycles = 0;
        run_one(1'b0, 1'b0, 24'h7E, 24'h0, lat, rd, er);
        chk("t4_bad_latency", lat, 0);
        chk("t4_bad_error", er, 1);
        chk("t4_bad_rdata", rd, 0);
        chk("t4_bad_no_write", wr_cycles, 0);
        run_one(1'b1, 1'b1, 24'h7D, 24'h123456, lat, rd, er);
        chk("t4_edge_error", er, 0);
        chk("t4_edge_mem", {ram[125], ram[126], ram[127]}, 24'h123456);

        // Reset in B1 of a store leaves only the first byte written.
        @(posedge clk); #1;
        req0 = 1'b1; write0 = 1'b1; addr0 = 24'h20; wdata0 = 24'h5A6B7C;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy_after_reset", busy, 0);
        chk("t5_no_ready", {ready1, ready0}, 0);
        chk("t5_mem", {ram[32], ram[33], ram[34]}, 24'h5A7477);
        run_one(1'b1, 1'b0, 24'h20, 24'h0, lat, rd, er);
        chk("t5_reload", rd, 24'h5A7477);
        chk("t5_reload_latency", lat, 3);

        // Request dropped and data changed right after grant.
        @(posedge clk); #1;
        req0 = 1'b1; write0 = 1'b1; addr0 = 24'h40; wdata0 = 24'h0F1E2D;
        @(posedge clk); #1;
        req0 = 1'b0; wdata0 = 24'hFFFFFF; addr0 = 24'h0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready0 === 1'b1) seen = 1'b1;
        end
        chk("t6_ready0", seen, 1);
        chk("t6_mem", {ram[64], ram[65], ram[66]}, 24'h0F1E2D);

        m = 0;
        for (int i = 0; i < 128; i++) if (ram[i] !== mdl_mem[i]) m++;
        chk("mem_image", m, 0);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
